// File: rtl/spi_cmd_master.sv
// SPI flash command master: CS setup, instruction out, optional dummy clocks, N bytes in, CS release.
// Define SPI_CMD_MASTER_DUMMY_EN to add the dummy_cycles input and the DUMMY phase.
module spi_cmd_master #(
  parameter int CLK_DIV      = 4,
  parameter int INST_BITS    = 8,
  parameter int MAX_RX_BYTES = 4,
  parameter bit CPOL         = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [INST_BITS-1:0]              inst,
  input  logic [$clog2(MAX_RX_BYTES+1)-1:0] rx_len,
`ifdef SPI_CMD_MASTER_DUMMY_EN
  input  logic [3:0]                        dummy_cycles,
`endif
  output logic                              busy,
  output logic                              done,
  output logic [8*MAX_RX_BYTES-1:0]         rx_data,
  output logic                              sclk,
  output logic                              cs_n,
  output logic                              mosi,
  input  logic                              miso
);

  localparam int LEN_W = $clog2(MAX_RX_BYTES + 1);
  localparam int RX_W  = 8 * MAX_RX_BYTES;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(INST_BITS + 8 * MAX_RX_BYTES + 16);

`ifdef SPI_CMD_MASTER_DUMMY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT_CS, S_SEND_INST, S_DUMMY, S_GET_DATA, S_DEASSERT_CS
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT_CS, S_SEND_INST, S_GET_DATA, S_DEASSERT_CS
  } state_t;
`endif

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic                 half_q;
  logic [BIT_W-1:0]     bit_q;
  logic [INST_BITS-2:0] inst_q;  // bits still to send after the MSB
  logic [LEN_W-1:0]     len_q;
  logic [RX_W-1:0]      rx_q;
  logic                 sclk_q, cs_n_q, mosi_q, busy_q, done_q;
`ifdef SPI_CMD_MASTER_DUMMY_EN
  logic [3:0]           dummy_q;
`endif

  logic                 div_end;
  logic                 last_inst, last_data;
  logic [LEN_W-1:0]     len_clamped;
  state_t               post_inst_d;

  assign div_end     = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_inst   = (bit_q == BIT_W'(INST_BITS - 1));
  assign last_data   = (bit_q == BIT_W'({len_q, 3'b000}) - BIT_W'(1));
  assign len_clamped = (rx_len > LEN_W'(MAX_RX_BYTES)) ? LEN_W'(MAX_RX_BYTES) : rx_len;

  always_comb begin
    post_inst_d = (len_q != '0) ? S_GET_DATA : S_DEASSERT_CS;
`ifdef SPI_CMD_MASTER_DUMMY_EN
    if (dummy_q != 4'd0) post_inst_d = S_DUMMY;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      inst_q  <= '0;
      len_q   <= '0;
      rx_q    <= '0;
      sclk_q  <= CPOL;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_CMD_MASTER_DUMMY_EN
      dummy_q <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start landing on the done cycle is deliberately dropped.
          if (start && !done_q) begin
            state_q <= S_ASSERT_CS;
            inst_q  <= inst[INST_BITS-2:0];
            mosi_q  <= inst[INST_BITS-1];
            len_q   <= len_clamped;
            rx_q    <= '0;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            sclk_q  <= CPOL;
            div_q   <= '0;
`ifdef SPI_CMD_MASTER_DUMMY_EN
            dummy_q <= dummy_cycles;
`endif
          end
        end
        S_ASSERT_CS: begin
          if (div_end) begin
            div_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            state_q <= S_SEND_INST;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_DEASSERT_CS: begin
          if (div_end) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          // Bit-period phases: half_q=0 holds sclk at CPOL, half_q=1 at ~CPOL.
          if (!div_end) begin
            div_q <= div_q + DIV_W'(1);
          end else if (!half_q) begin
            div_q  <= '0;
            half_q <= 1'b1;
            sclk_q <= ~CPOL;
            if (state_q == S_GET_DATA) rx_q <= {rx_q[RX_W-2:0], miso};
          end else begin
            div_q  <= '0;
            half_q <= 1'b0;
            sclk_q <= CPOL;
            bit_q  <= bit_q + BIT_W'(1);
            case (state_q)
              S_SEND_INST: begin
                if (last_inst) begin
                  bit_q   <= '0;
                  mosi_q  <= 1'b0;
                  state_q <= post_inst_d;
                  if (post_inst_d == S_DEASSERT_CS) cs_n_q <= 1'b1;
                end else begin
                  mosi_q <= inst_q[INST_BITS-2];
                  inst_q <= inst_q << 1;
                end
              end
`ifdef SPI_CMD_MASTER_DUMMY_EN
              S_DUMMY: begin
                if (bit_q == BIT_W'(dummy_q) - BIT_W'(1)) begin
                  bit_q <= '0;
                  if (len_q != '0) begin
                    state_q <= S_GET_DATA;
                  end else begin
                    state_q <= S_DEASSERT_CS;
                    cs_n_q  <= 1'b1;
                  end
                end
              end
`endif
              S_GET_DATA: begin
                if (last_data) begin
                  bit_q   <= '0;
                  state_q <= S_DEASSERT_CS;
                  cs_n_q  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule
